// File: rtl/clk_manip_pkg.sv
// Shared types for the clock-manipulation pair; no logic, no latency.
package clk_manip_pkg;

  typedef enum logic [1:0] {
    P2E_IDLE = 2'd0,
    P2E_HIGH = 2'd1,
    P2E_LOW  = 2'd2
  } p2e_state_e;

  localparam int P2E_LEN_W_DEF  = 4;
  localparam int P2E_PEND_W_DEF = 3;

endpackage

// File: rtl/p2e_pend_counter.sv
// Saturating up/down counter of queued events; count updates one cycle after inc/dec.
// Simultaneous inc and dec leave the count unchanged; inc while full is ignored (caller flags the drop).
module p2e_pend_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         full_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && !full_o) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == {W{1'b1}});

endmodule

// File: rtl/pulse2edge_stretcher.sv
// Stretches fast-domain pulses into L-cycle high levels separated by L-cycle low gaps (edge_o rises 1 cycle after pulse_i).
// No backpressure: surplus pulses queue in the pending counter, and are dropped with a sticky overflow once it is full.
module pulse2edge_stretcher
  import clk_manip_pkg::*;
#(
  parameter int LEN_W  = P2E_LEN_W_DEF,
  parameter int PEND_W = P2E_PEND_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_i,
  input  logic [LEN_W-1:0]  hold_len_i,
  input  logic              clear_ovf_i,
  output logic              edge_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  p2e_state_e        state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_m1;
  logic              ovf_q, ovf_d;
  logic              enq, deq, drop;
  logic              phase_done;
  logic              pend_full;
  logic [PEND_W-1:0] pend_cnt;

  // A zero hold length behaves as one cycle.
  assign len_m1     = (hold_len_i == '0) ? '0 : hold_len_i - LEN_W'(1);
  assign phase_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enq     = 1'b0;
    deq     = 1'b0;
    case (state_q)
      P2E_IDLE: begin
        if (pulse_i) begin
          state_d = P2E_HIGH;
          cnt_d   = len_m1;
        end
      end
      P2E_HIGH: begin
        enq = pulse_i;
        if (phase_done) begin
          state_d = P2E_LOW;
          cnt_d   = len_m1;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      P2E_LOW: begin
        if (!phase_done) begin
          enq   = pulse_i;
          cnt_d = cnt_q - LEN_W'(1);
        end else if (pend_cnt != '0) begin
          // Replay a queued event; a pulse arriving now takes the freed slot.
          state_d = P2E_HIGH;
          cnt_d   = len_m1;
          deq     = 1'b1;
          enq     = pulse_i;
        end else if (pulse_i) begin
          state_d = P2E_HIGH;
          cnt_d   = len_m1;
        end else begin
          state_d = P2E_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = P2E_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign drop = enq && pend_full && !deq;

  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P2E_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  p2e_pend_counter #(
    .W(PEND_W)
  ) u_pend (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (enq),
    .dec_i  (deq),
    .count_o(pend_cnt),
    .full_o (pend_full)
  );

  assign edge_o     = (state_q == P2E_HIGH);
  assign busy_o     = (state_q != P2E_IDLE);
  assign pending_o  = pend_cnt;
  assign overflow_o = ovf_q;

endmodule
